// File: rtl/shift_in.sv
// Serial-in, parallel-out receiver: captures width bits LSB first after start and
// hands completed words to a consumer through a valid/ack holding register.
module shift_in #(
   parameter int unsigned width  = 32,
   parameter int unsigned cwidth = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             enable,
   input  logic             sin,
   input  logic             ack,
   output logic [width-1:0] data_out,
   output logic             valid,
   output logic             busy,
   output logic             overrun
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e              state_q, state_d;
   logic [cwidth-1:0]   idx_q, idx_d;
   logic [width-1:0]    shreg_q, shreg_d;
   logic [width-1:0]    data_q, data_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;
   logic                complete;

   localparam logic [cwidth-1:0] LastIdx = cwidth'(width - 1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      complete  = 1'b0;

      // start beats enable, including on what would have been the completion edge
      if (start) begin
         state_d = StShift;
         idx_d   = '0;
      end else if (state_q == StShift && enable) begin
         shreg_d[idx_q] = sin;
         idx_d          = idx_q + 1'b1;
         if (idx_q == LastIdx) begin
            complete = 1'b1;
            state_d  = StIdle;
         end
      end

      if (valid_q && ack) begin
         valid_d = 1'b0;
      end

      // Holding register is free if empty or being drained on this same edge
      if (complete) begin
         if (!valid_q || ack) begin
            data_d  = shreg_d;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
   assign busy     = (state_q == StShift);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_shift_in.sv
// Directed bench for shift_in: loopback timing, gapped enable, overrun, same-edge ack,
// restart priority and reset mid-capture.
module tb_shift_in;

   logic        clk = 1'b0;
   logic        reset, start, enable, sin, ack;
   logic [31:0] data_out;
   logic        valid, busy, overrun;

   int n_checks = 0;
   int n_errors = 0;

   shift_in #(.width(32), .cwidth(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .enable   (enable),
      .sin      (sin),
      .ack      (ack),
      .data_out (data_out),
      .valid    (valid),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Transmitter model: start cycle with enable high, then gap idle cycles before each bit.
   task automatic send(input logic [31:0] w, input int gap, input bit ack_last,
                       input logic exp_valid_pre);
      start  = 1'b1;
      enable = 1'b1;
      sin    = ~w[0];
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int i = 0; i < 32; i++) begin
         enable = 1'b0;
         repeat (gap) step();
         enable = 1'b1;
         sin    = w[i];
         if (i == 31) begin
            ack = ack_last;
            chk("valid_before_last", valid, exp_valid_pre);
            chk("busy_before_last", busy, 1);
         end
         step();
      end
      enable = 1'b0;
      ack    = 1'b0;
   endtask

   task automatic partial(input logic [31:0] w, input int n);
      start  = 1'b1;
      enable = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         sin = w[i];
         step();
      end
      enable = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; enable = 1'b0; sin = 1'b0; ack = 1'b0;
      do_reset();
      chk("rst_data", data_out, 32'h0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);

      // Loopback with enable held high: word lands 32 clocks after start edge
      send(32'hA5C3_0F81, 0, 1'b0, 1'b0);
      chk("loop_data", data_out, 32'hA5C3_0F81);
      chk("loop_valid", valid, 1);
      chk("loop_busy", busy, 0);
      do_ack();
      chk("ack_clears_valid", valid, 0);
      do_ack();
      chk("ack_idle_nop", valid, 0);

      // 1-of-3 enable
      send(32'h0000_0001, 2, 1'b0, 1'b0);
      chk("gap_data", data_out, 32'h0000_0001);
      chk("gap_valid", valid, 1);
      do_ack();

      // Overrun
      send(32'h1111_1111, 0, 1'b0, 1'b0);
      send(32'h2222_2222, 0, 1'b0, 1'b1);
      chk("ovr_data", data_out, 32'h1111_1111);
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", valid, 1);
      do_ack();
      chk("ovr_sticky", overrun, 1);
      chk("ovr_acked", valid, 0);

      do_reset();
      chk("rst2_overrun", overrun, 0);

      // ack on completion edge passes the new word straight through
      send(32'h1111_1111, 0, 1'b0, 1'b0);
      send(32'h3333_3333, 0, 1'b1, 1'b1);
      chk("same_valid", valid, 1);
      chk("same_data", data_out, 32'h3333_3333);
      chk("same_overrun", overrun, 0);
      do_ack();

      // Restart after 10 bits
      partial(32'hFFFF_FFFF, 10);
      chk("partial_busy", busy, 1);
      send(32'hFFFF_0000, 0, 1'b0, 1'b0);
      chk("restart_data", data_out, 32'hFFFF_0000);
      do_ack();

      // start on the completion edge wins: nothing transferred
      partial(32'h5555_5555, 31);
      start  = 1'b1;
      enable = 1'b1;
      sin    = 1'b1;
      step();
      start  = 1'b0;
      enable = 1'b0;
      chk("startlast_valid", valid, 0);
      chk("startlast_busy", busy, 1);
      chk("startlast_data", data_out, 32'hFFFF_0000);
      send(32'h0F0F_F0F0, 0, 1'b0, 1'b0);
      chk("after_startlast", data_out, 32'h0F0F_F0F0);
      do_ack();

      // enable in IDLE is ignored
      enable = 1'b1;
      sin    = 1'b1;
      repeat (5) step();
      enable = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
      chk("idle_data", data_out, 32'h0F0F_F0F0);

      // Reset mid-capture with a word pending
      send(32'h1234_5678, 0, 1'b0, 1'b0);
      partial(32'hFFFF_FFFF, 20);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_data", data_out, 32'h0);
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_overrun", overrun, 0);
      send(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      chk("postrst_data", data_out, 32'hDEAD_BEEF);
      chk("postrst_valid", valid, 1);

      // Back-to-back start right after completion
      send(32'hCAFE_0123, 0, 1'b1, 1'b1);
      chk("b2b_data", data_out, 32'hCAFE_0123);
      chk("b2b_overrun", overrun, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
